// File: rtl/racetrack_defines.sv
// Shared types and defaults for the racetrack memory controller.
// Holds the controller state encoding, requester ids and shift-latency helper.
package racetrack_defines;

   localparam int unsigned DEF_SHIFT_CYC = 2;
   localparam int unsigned DEF_TIMEOUT   = 15;
   localparam int unsigned BE_WIDTH      = 4;
   localparam int unsigned N_PORTS       = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SHIFT  = 3'd1,
      ST_ACCESS = 3'd2,
      ST_WAIT   = 3'd3,
      ST_RESP   = 3'd4
   } rt_state_e;

   // Requester index doubles as the arbiter request/grant bit position.
   typedef enum logic {
      REQ_INSTR = 1'b0,
      REQ_DATA  = 1'b1
   } rt_port_e;

   // Clock cycles needed to move the track by n_shift domain positions.
   function automatic int unsigned shift_cycles(input logic [1:0] n_shift,
                                                input int unsigned cyc_per_step);
      return 32'(n_shift) * cyc_per_step;
   endfunction

endpackage

// File: rtl/rt_rr_arbiter.sv
// Two-way round-robin arbiter: one-hot grant, last-grant register.
// A lone requester always wins; on a tie the port not granted last wins.
module rt_rr_arbiter
   import racetrack_defines::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_PORTS-1:0] req,
   input  logic               update,
   output logic [N_PORTS-1:0] gnt_c
);

   logic last_data_q;

   always_comb begin : grant_select
      gnt_c = req;
      if (&req) begin
         gnt_c = last_data_q ? N_PORTS'(1) : N_PORTS'(2);
      end
   end

   // Reset to "instr granted last" so data wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin : last_grant_reg
      if (!rst_n) begin
         last_data_q <= 1'b0;
      end else if (update && (|gnt_c)) begin
         last_data_q <= gnt_c[REQ_DATA];
      end
   end

endmodule

// File: rtl/rt_mem_ctrl.sv
// Racetrack memory controller: arbitrates instr/data ports, shifts the track
// to the addressed domain, issues one read/write pulse and returns a response.
module rt_mem_ctrl
   import racetrack_defines::*;
#(
   parameter int unsigned ADDR_WIDTH = 9,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned SHIFT_CYC  = DEF_SHIFT_CYC,
   parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,

   input  logic                  instr_req_i,
   input  logic [ADDR_WIDTH-1:0] instr_addr_i,
   output logic                  instr_gnt_o,
   output logic                  instr_rvalid_o,
   output logic [DATA_WIDTH-1:0] instr_rdata_o,

   input  logic                  data_req_i,
   input  logic                  data_we_i,
   input  logic [BE_WIDTH-1:0]   data_be_i,
   input  logic [ADDR_WIDTH-1:0] data_addr_i,
   input  logic [DATA_WIDTH-1:0] data_wdata_i,
   output logic                  data_gnt_o,
   output logic                  data_rvalid_o,
   output logic [DATA_WIDTH-1:0] data_rdata_o,

   output logic                  mem_en_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [BE_WIDTH-1:0]   mem_be_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   output logic                  mem_we_o,
   output logic                  mem_write_pulse_o,
   output logic                  mem_read_pulse_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   input  logic                  mem_rvalid_i,

   output logic                  busy_o,
   output logic                  err_o
);

   localparam int unsigned MAX_SHIFT = 3 * SHIFT_CYC;
   localparam int unsigned CNT_MAX   = (MAX_SHIFT > TIMEOUT) ? MAX_SHIFT : TIMEOUT;
   localparam int unsigned CNT_W     = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

   rt_state_e             state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   rt_port_e              owner_q, owner_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  we_q, we_d;
   logic [BE_WIDTH-1:0]   be_q, be_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   logic                  instr_gnt_nxt, data_gnt_nxt;
   logic                  read_pulse_nxt, write_pulse_nxt;
   logic                  timeout_nxt;
   logic [DATA_WIDTH-1:0] rdata_nxt;

   logic [N_PORTS-1:0]    arb_req, arb_gnt;
   logic                  arb_update;

   logic                  sel_data;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic                  sel_we;
   logic [BE_WIDTH-1:0]   sel_be;
   logic [DATA_WIDTH-1:0] sel_wdata;
   int unsigned           sel_len;

   assign arb_req    = {data_req_i, instr_req_i};
   assign arb_update = (state_q == ST_IDLE) && (|arb_req);

   rt_rr_arbiter u_arb (
      .clk    (clk_i),
      .rst_n  (rstn_i),
      .req    (arb_req),
      .update (arb_update),
      .gnt_c  (arb_gnt)
   );

   // Request payload of the arbitration winner; instr fetches are full-word reads.
   always_comb begin : winner_mux
      sel_data  = arb_gnt[REQ_DATA];
      sel_addr  = sel_data ? data_addr_i : instr_addr_i;
      sel_we    = sel_data & data_we_i;
      sel_be    = sel_data ? data_be_i : '1;
      sel_wdata = sel_data ? data_wdata_i : '0;
      sel_len   = shift_cycles(sel_addr[3:2], SHIFT_CYC);
   end

   always_comb begin : fsm_next
      state_d         = state_q;
      cnt_d           = cnt_q;
      owner_d         = owner_q;
      addr_d          = addr_q;
      we_d            = we_q;
      be_d            = be_q;
      wdata_d         = wdata_q;
      instr_gnt_nxt   = 1'b0;
      data_gnt_nxt    = 1'b0;
      read_pulse_nxt  = 1'b0;
      write_pulse_nxt = 1'b0;
      timeout_nxt     = 1'b0;
      rdata_nxt       = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (|arb_req) begin
               instr_gnt_nxt = arb_gnt[REQ_INSTR];
               data_gnt_nxt  = arb_gnt[REQ_DATA];
               owner_d       = sel_data ? REQ_DATA : REQ_INSTR;
               addr_d        = sel_addr;
               we_d          = sel_we;
               be_d          = sel_be;
               wdata_d       = sel_wdata;
               if (sel_len != 0) begin
                  state_d = ST_SHIFT;
                  cnt_d   = CNT_W'(sel_len - 1);
               end else begin
                  state_d         = ST_ACCESS;
                  write_pulse_nxt = sel_we;
                  read_pulse_nxt  = ~sel_we;
               end
            end
         end
         ST_SHIFT: begin
            if (cnt_q == '0) begin
               state_d         = ST_ACCESS;
               write_pulse_nxt = we_q;
               read_pulse_nxt  = ~we_q;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_ACCESS: begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(TIMEOUT - 1);
         end
         // A late mem_rvalid_i on the last WAIT cycle still counts as a hit.
         ST_WAIT: begin
            if (mem_rvalid_i) begin
               state_d   = ST_RESP;
               rdata_nxt = we_q ? '0 : mem_rdata_i;
            end else if (cnt_q == '0) begin
               state_d     = ST_RESP;
               timeout_nxt = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin : ctx_reg
      if (!rstn_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         owner_q <= REQ_INSTR;
         addr_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
      end
   end

   // Every port-visible strobe is registered from the next-state decode.
   always_ff @(posedge clk_i or negedge rstn_i) begin : out_reg
      if (!rstn_i) begin
         instr_gnt_o       <= 1'b0;
         data_gnt_o        <= 1'b0;
         instr_rvalid_o    <= 1'b0;
         data_rvalid_o     <= 1'b0;
         instr_rdata_o     <= '0;
         data_rdata_o      <= '0;
         mem_en_o          <= 1'b0;
         mem_we_o          <= 1'b0;
         mem_write_pulse_o <= 1'b0;
         mem_read_pulse_o  <= 1'b0;
         busy_o            <= 1'b0;
         err_o             <= 1'b0;
      end else begin
         instr_gnt_o       <= instr_gnt_nxt;
         data_gnt_o        <= data_gnt_nxt;
         instr_rvalid_o    <= (state_d == ST_RESP) && (owner_d == REQ_INSTR);
         data_rvalid_o     <= (state_d == ST_RESP) && (owner_d == REQ_DATA);
         instr_rdata_o     <= (owner_d == REQ_INSTR) ? rdata_nxt : '0;
         data_rdata_o      <= (owner_d == REQ_DATA) ? rdata_nxt : '0;
         mem_en_o          <= (state_d inside {ST_SHIFT, ST_ACCESS, ST_WAIT});
         mem_we_o          <= write_pulse_nxt;
         mem_write_pulse_o <= write_pulse_nxt;
         mem_read_pulse_o  <= read_pulse_nxt;
         busy_o            <= (state_d != ST_IDLE);
         err_o             <= timeout_nxt;
      end
   end

   assign mem_addr_o  = addr_q;
   assign mem_be_o    = be_q;
   assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_rt_mem_ctrl.sv
// Scoreboard bench for rt_mem_ctrl: port drivers push expectations, a memory
// responder emulates the racetrack array, a monitor checks every response.
module tb_rt_mem_ctrl;

   localparam int unsigned AW    = 9;
   localparam int unsigned DW    = 32;
   localparam int unsigned SC    = 2;
   localparam int unsigned TO    = 15;
   localparam int          NEVER = 100;

   logic          clk = 1'b0;
   logic          rstn = 1'b1;
   logic          instr_req = 1'b0;
   logic [AW-1:0] instr_addr = '0;
   logic          instr_gnt, instr_rvalid;
   logic [DW-1:0] instr_rdata;
   logic          data_req = 1'b0, data_we = 1'b0;
   logic [3:0]    data_be = '0;
   logic [AW-1:0] data_addr = '0;
   logic [DW-1:0] data_wdata = '0;
   logic          data_gnt, data_rvalid;
   logic [DW-1:0] data_rdata;
   logic          mem_en, mem_we, mem_write_pulse, mem_read_pulse;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_be;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_rvalid = 1'b0;
   logic          busy, err;

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   rt_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SHIFT_CYC(SC), .TIMEOUT(TO)) dut (
      .clk_i(clk), .rstn_i(rstn),
      .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
      .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
      .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
      .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt),
      .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
      .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
      .mem_we_o(mem_we), .mem_write_pulse_o(mem_write_pulse), .mem_read_pulse_o(mem_read_pulse),
      .mem_rdata_i(mem_rdata), .mem_rvalid_i(mem_rvalid),
      .busy_o(busy), .err_o(err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      bit            is_data;
      logic [AW-1:0] addr;
      bit            we;
      logic [3:0]    be;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
      int unsigned   gnt_cyc;
   } exp_t;

   typedef struct {
      int unsigned   cyc;
      logic [AW-1:0] addr;
      bit            we;
      bit            en;
      bit            we_en;
      logic [3:0]    be;
      logic [DW-1:0] wdata;
      bit            never;
      int            d;
   } acc_t;

   exp_t          exp_q[$];
   acc_t          acc_q[$];
   bit            grant_log[$];
   logic [DW-1:0] ref_mem[128];
   logic [DW-1:0] dev_mem[128];
   int            forced_d = -1;

   function automatic logic [DW-1:0] merge_be(input logic [DW-1:0] old_w,
                                              input logic [DW-1:0] new_w,
                                              input logic [3:0] be);
      merge_be = old_w;
      for (int b = 0; b < 4; b++) if (be[b]) merge_be[8*b +: 8] = new_w[8*b +: 8];
   endfunction

   // Issue one request, hold it until granted, then record what must come back.
   task automatic issue(input bit is_data, input logic [AW-1:0] addr, input bit we,
                        input logic [3:0] be, input logic [DW-1:0] wdata, input bit no_gap);
      exp_t e;
      bit   got;
      got = 1'b0;
      if (!no_gap) @(negedge clk);
      if (is_data) begin
         data_req = 1'b1; data_we = we; data_be = be; data_addr = addr; data_wdata = wdata;
      end else begin
         instr_req = 1'b1; instr_addr = addr;
      end
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (is_data ? data_gnt : instr_gnt) begin
            got = 1'b1;
            break;
         end
      end
      if (is_data) data_req = 1'b0; else instr_req = 1'b0;
      check(is_data ? "data_gnt_wait" : "instr_gnt_wait", 64'(got), 64'd1);
      if (got) begin
         grant_log.push_back(is_data);
         e.is_data = is_data; e.addr = addr; e.we = is_data & we; e.be = be;
         e.wdata = wdata; e.gnt_cyc = cyc;
         if (e.we) begin
            ref_mem[addr[AW-1:2]] = merge_be(ref_mem[addr[AW-1:2]], wdata, be);
            e.rdata = '0;
         end else begin
            e.rdata = ref_mem[addr[AW-1:2]];
         end
         exp_q.push_back(e);
      end
   endtask

   // Memory array emulation: serves each access pulse after a chosen delay.
   initial begin : responder
      int            fire_at, spur_at, d;
      logic [DW-1:0] fire_data;
      acc_t          a;
      fire_at = -1; spur_at = -1; fire_data = '0;
      forever begin
         @(negedge clk);
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
         if (!rstn) begin
            fire_at = -1; spur_at = -1;
            continue;
         end
         if (int'(cyc) == fire_at) begin
            mem_rvalid = 1'b1; mem_rdata = fire_data;
         end else if (int'(cyc) == spur_at) begin
            mem_rvalid = 1'b1;
         end
         if (mem_read_pulse || mem_write_pulse) begin
            check("pulse_exclusive", 64'(mem_read_pulse & mem_write_pulse), 64'd0);
            if (forced_d >= 0) d = forced_d;
            else if ($urandom_range(9, 0) == 0) d = NEVER;
            else if ($urandom_range(4, 0) == 0) d = int'($urandom_range(TO, 1));
            else d = int'($urandom_range(4, 1));
            a.cyc = cyc; a.addr = mem_addr; a.we = mem_write_pulse; a.en = mem_en;
            a.we_en = mem_we; a.be = mem_be; a.wdata = mem_wdata; a.never = (d == NEVER); a.d = d;
            acc_q.push_back(a);
            if (mem_write_pulse)
               dev_mem[mem_addr[AW-1:2]] = merge_be(dev_mem[mem_addr[AW-1:2]], mem_wdata, mem_be);
            fire_data = dev_mem[mem_addr[AW-1:2]];
            if (d == NEVER) begin
               fire_at = -1;
               spur_at = int'(cyc) + int'(TO) + 1;
            end else begin
               fire_at = int'(cyc) + d;
               spur_at = ($urandom_range(1, 0) == 1) ? int'(cyc) + d + 1 : -1;
            end
         end
      end
   end

   // Response monitor: pops the oldest expectation on every rvalid.
   initial begin : monitor
      exp_t        e;
      acc_t        a;
      int unsigned k, exp_cyc;
      bit          prev_gnt, resp_prev;
      prev_gnt = 1'b0; resp_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            prev_gnt = 1'b0; resp_prev = 1'b0;
            continue;
         end
         if (resp_prev) check("idle_after_resp", 64'(busy), 64'd0);
         resp_prev = 1'b0;
         if (instr_gnt || data_gnt)
            check("gnt_onehot_pulse", 64'({instr_gnt & data_gnt, prev_gnt}), 64'd0);
         prev_gnt = instr_gnt | data_gnt;
         if (!(instr_rvalid || data_rvalid)) begin
            if (err) check("err_without_rvalid", 64'(err), 64'd0);
            continue;
         end
         resp_prev = 1'b1;
         if (exp_q.size() == 0) begin
            check("unexpected_rvalid", 64'd1, 64'd0);
            continue;
         end
         e = exp_q.pop_front();
         if (acc_q.size() == 0) begin
            check("missing_mem_pulse", 64'd1, 64'd0);
            continue;
         end
         a = acc_q.pop_front();
         k = 32'(e.addr[3:2]) * SC;
         check("rvalid_port", 64'({instr_rvalid, data_rvalid}), e.is_data ? 64'd1 : 64'd2);
         check("pulse_cycle", 64'(a.cyc), 64'(e.gnt_cyc + k));
         check("mem_addr", 64'(a.addr), 64'(e.addr));
         check("pulse_kind", 64'(a.we), 64'(e.we));
         check("mem_en", 64'(a.en), 64'd1);
         check("mem_we", 64'(a.we_en), 64'(e.we));
         if (e.is_data) check("mem_be", 64'(a.be), 64'(e.be));
         if (e.we) check("mem_wdata", 64'(a.wdata), 64'(e.wdata));
         exp_cyc = e.gnt_cyc + k + (a.never ? TO + 1 : 32'(a.d) + 1);
         check("rvalid_cycle", 64'(cyc), 64'(exp_cyc));
         check("rdata", 64'(e.is_data ? data_rdata : instr_rdata),
               (a.never || e.we) ? 64'd0 : 64'(e.rdata));
         check("err", 64'(err), 64'(a.never));
      end
   end

   task automatic check_reset_zero(input string tag);
      check({tag, "_ctrl"}, 64'({busy, instr_gnt, data_gnt, instr_rvalid, data_rvalid,
                                 mem_en, mem_we, mem_write_pulse, mem_read_pulse, err}), 64'd0);
      check({tag, "_rdata"}, {instr_rdata, data_rdata}, 64'd0);
      check({tag, "_mem_bus"}, 64'({mem_addr, mem_be, mem_wdata}), 64'd0);
   endtask

   task automatic drain();
      for (int i = 0; i < 300; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      check("drain", 64'(exp_q.size()), 64'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin : watchdog
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [DW-1:0] v;
      for (int i = 0; i < 128; i++) begin
         v = $urandom;
         ref_mem[i] = v;
         dev_mem[i] = v;
      end
      #2 rstn = 1'b0;
      #1 check_reset_zero("por");
      repeat (3) @(negedge clk);
      rstn = 1'b1;

      // zero-shift instr fetch, memory answers two cycles after grant
      forced_d = 2;
      issue(1'b0, 9'h000, 1'b0, 4'hF, '0, 1'b0);
      drain();

      // three-step shift write, then read it back
      forced_d = 3;
      issue(1'b1, 9'h00C, 1'b1, 4'hF, 32'hA5A5_1234, 1'b0);
      drain();
      issue(1'b1, 9'h00C, 1'b0, 4'hF, '0, 1'b0);
      drain();
      issue(1'b1, 9'h00C, 1'b1, 4'b0101, 32'h1122_3344, 1'b0);
      drain();
      issue(1'b0, 9'h00C, 1'b0, 4'hF, '0, 1'b0);
      drain();

      // memory never answers: timeout response
      forced_d = NEVER;
      issue(1'b0, 9'h004, 1'b0, 4'hF, '0, 1'b0);
      drain();
      issue(1'b1, 9'h1F8, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0);
      drain();

      // both ports requesting continuously after reset
      forced_d = 1;
      pulse_reset();
      grant_log.delete();
      fork
         begin
            issue(1'b1, 9'h010, 1'b0, 4'hF, '0, 1'b0);
            issue(1'b1, 9'h024, 1'b1, 4'hF, 32'h0BAD_F00D, 1'b1);
         end
         begin
            issue(1'b0, 9'h008, 1'b0, 4'hF, '0, 1'b0);
            issue(1'b0, 9'h03C, 1'b0, 4'hF, '0, 1'b1);
         end
      join
      drain();
      check("arb_count", 64'(grant_log.size()), 64'd4);
      if (grant_log.size() == 4)
         check("arb_order", 64'({grant_log[0], grant_log[1], grant_log[2], grant_log[3]}), 64'b1010);

      // randomized traffic on both ports
      forced_d = -1;
      fork
         for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(3, 0)) @(negedge clk);
            issue(1'b0, AW'($urandom) & ~AW'(3), 1'b0, 4'hF, '0, 1'b0);
         end
         for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(3, 0)) @(negedge clk);
            issue(1'b1, AW'($urandom), 1'($urandom), 4'($urandom), $urandom, 1'b0);
         end
      join
      drain();

      // reset while shifting: access abandoned, nothing comes back
      forced_d = 2;
      issue(1'b1, 9'h00C, 1'b0, 4'hF, '0, 1'b0);
      @(negedge clk);
      rstn = 1'b0;
      #1 check_reset_zero("mid_shift");
      exp_q.delete();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (30) @(negedge clk);
      check("no_access_after_reset", 64'(acc_q.size()), 64'd0);
      issue(1'b0, 9'h008, 1'b0, 4'hF, '0, 1'b0);
      drain();

      check("acc_leftover", 64'(acc_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
